// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and exception codes.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int unsigned SR_IE       = 0;
  localparam int unsigned SR_EXL      = 1;
  localparam int unsigned SR_IM_LO    = 10;
  localparam int unsigned SR_IM_HI    = 15;
  localparam logic [31:0] SR_WMASK    = 32'h0000_FC03;

  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT       = 32'h4C5A_5142;

endpackage

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception controller at the M stage: SR/Cause/EPC/PRId, request
// generation for the D-stage PC mux, eret handling and mtc0/mfc0 access.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] PRID_VALUE = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic [5:0]  hw_int,
  input  logic        eret_m,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc,
  output logic        exl
);

  // The handler vector feeds the PC mux directly, so it must be word aligned.
  if (EXC_VECTOR[1:0] != 2'b00) begin : g_vec_check
    $error("cp0_ctrl: EXC_VECTOR must be word aligned");
  end

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req, exc_req;
  logic [31:0] victim_pc;

  assign int_req = (|(hw_int & sr_q[SR_IM_HI:SR_IM_LO])) & sr_q[SR_IE] & ~sr_q[SR_EXL];
  assign exc_req = (exc_code_m != 5'd0) & ~sr_q[SR_EXL];
  assign req     = int_req | exc_req;

  assign victim_pc = bd_m ? (pc_m - 32'd4) : pc_m;

  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cause_d[CAUSE_IP_HI:CAUSE_IP_LO] = hw_int;
    if (req) begin
      sr_d[SR_EXL]      = 1'b1;
      cause_d[CAUSE_BD] = bd_m;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = int_req ? EXC_INT : exc_code_m;
      epc_d = {victim_pc[31:2], 2'b00};
    end else begin
      if (eret_m) begin
        sr_d[SR_EXL] = 1'b0;
      end
      if (we) begin
        case (addr)
          CP0_SR:  sr_d  = wdata & SR_WMASK;
          CP0_EPC: epc_d = {wdata[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR:    rdata = sr_q;
      CP0_CAUSE: rdata = cause_q;
      CP0_EPC:   rdata = epc_q;
      CP0_PRID:  rdata = PRID_VALUE;
      default:   rdata = '0;
    endcase
  end

  assign epc = epc_q;
  assign exl = sr_q[SR_EXL];

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios followed by randomized traffic
// compared against a field-level behavioural model.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] epc;
  logic        exl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] PRID = 32'h4C5A_5142;

  always #5 clk = ~clk;

  cp0_ctrl #(.EXC_VECTOR(32'h0000_4180), .PRID_VALUE(PRID)) dut (
    .clk(clk), .reset_n(reset_n), .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m),
    .hw_int(hw_int), .eret_m(eret_m), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .req(req), .epc(epc), .exl(exl)
  );

  // Behavioural model: architectural fields held as plain values.
  logic [5:0]  m_im;
  logic        m_ie, m_exl, m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_code;
  logic [31:0] m_epc;

  function automatic logic [31:0] m_sr();
    return {16'd0, m_im, 8'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int_req();
    return ((hw_int & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((exc_code_m != 5'd0) && !m_exl);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0;
    m_ip = '0; m_code = '0; m_epc = '0;
  endtask

  // Applies one cycle of M-stage inputs, checks combinational outputs, then advances the model.
  task automatic step(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                      input logic [5:0] hw, input logic er, input logic w,
                      input logic [4:0] a, input logic [31:0] wd);
    logic r, ir;
    @(negedge clk);
    pc_m = pc; bd_m = bd; exc_code_m = code; hw_int = hw;
    eret_m = er; we = w; addr = a; wdata = wd;
    #1;
    r  = m_req();
    ir = m_int_req();
    chk("req", 32'(req), 32'(r));
    chk("rdata", rdata, m_read(a));
    chk("epc", epc, m_epc);
    chk("exl", 32'(exl), 32'(m_exl));
    @(posedge clk);
    if (r) begin
      m_exl  = 1'b1;
      m_bd   = bd;
      m_code = ir ? 5'd0 : code;
      m_epc  = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    end else begin
      if (er) m_exl = 1'b0;
      if (w) begin
        if (a == 5'd12) begin
          m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
        end else if (a == 5'd14) begin
          m_epc = wd & 32'hFFFF_FFFC;
        end
      end
    end
    m_ip = hw;
  endtask

  task automatic idle(input logic [4:0] a, input logic [5:0] hw);
    step(32'h0000_1000, 1'b0, 5'd0, hw, 1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pc_m = '0; bd_m = 1'b0; exc_code_m = '0; hw_int = '0;
    eret_m = 1'b0; we = 1'b0; wdata = '0; addr = 5'd12;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_exl", 32'(exl), 32'd0);
    for (int unsigned i = 12; i <= 15; i++) begin
      addr = 5'(i);
      #1;
      chk("rst_read", rdata, (i == 15) ? PRID : 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0] codes [8];
    logic [4:0] a;
    logic       er, w;
    codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    reset_n = 1'b1;
    pc_m = '0; bd_m = 1'b0; exc_code_m = '0; hw_int = '0;
    eret_m = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_clear();
    #2 reset_n = 1'b0;
    #10;
    do_reset();

    // Exception from a branch delay slot.
    step(32'h0000_3010, 1'b1, 5'd12, 6'd0, 1'b0, 1'b0, 5'd13, 32'd0);
    idle(5'd13, 6'd0);
    chk("bd_epc", epc, 32'h0000_300C);
    chk("bd_cause", rdata, 32'h8000_0030);
    chk("bd_exl", 32'(exl), 32'd1);
    // A second exception is masked while EXL is set.
    step(32'h0000_3020, 1'b0, 5'd8, 6'd0, 1'b0, 1'b0, 5'd14, 32'd0);
    chk("masked_by_exl", 32'(req), 32'd0);
    step(32'h0000_3020, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 5'd12, 32'd0);
    idle(5'd12, 6'd0);
    chk("eret_exl", 32'(exl), 32'd0);

    // Interrupt masked by IM, then enabled.
    step(32'h0000_2000, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 5'd12, 32'h0000_0401);
    step(32'h0000_2004, 1'b0, 5'd0, 6'b000010, 1'b0, 1'b0, 5'd12, 32'd0);
    chk("im_masked", 32'(req), 32'd0);
    step(32'h0000_2008, 1'b0, 5'd0, 6'b000010, 1'b0, 1'b1, 5'd12, 32'h0000_0801);
    step(32'h0000_200C, 1'b0, 5'd0, 6'b000010, 1'b0, 1'b0, 5'd13, 32'd0);
    chk("int_req", 32'(req), 32'd1);
    idle(5'd13, 6'b000010);
    chk("int_cause", rdata, 32'h0000_0800);
    chk("int_epc", epc, 32'h0000_200C);

    // eret with the interrupt still pending: taken the following cycle.
    step(32'h0000_4190, 1'b0, 5'd0, 6'b000010, 1'b1, 1'b0, 5'd12, 32'd0);
    chk("eret_cycle_req", 32'(req), 32'd0);
    idle(5'd12, 6'b000010);
    chk("eret_pending_req", 32'(req), 32'd1);

    // Interrupt beats exception; concurrent EPC write is dropped.
    step(32'h0000_4194, 1'b0, 5'd0, 6'b000010, 1'b1, 1'b0, 5'd12, 32'd0);
    step(32'h0000_5000, 1'b0, 5'd10, 6'b000010, 1'b0, 1'b1, 5'd14, 32'hDEAD_BEEF);
    chk("prio_req", 32'(req), 32'd1);
    idle(5'd13, 6'd0);
    chk("prio_epc", epc, 32'h0000_5000);
    chk("prio_cause", rdata, 32'h0000_0800);

    // EPC write alignment and ignored Cause write.
    step(32'h0000_4198, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 5'd12, 32'd0);
    step(32'h0000_0100, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h0000_3007);
    idle(5'd13, 6'd0);
    chk("epc_align", epc, 32'h0000_3004);
    step(32'h0000_0104, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF);
    idle(5'd13, 6'd0);
    chk("cause_ro", rdata, 32'h0000_0000);

    // Reset in the middle of a handler.
    step(32'h0000_0200, 1'b0, 5'd4, 6'd0, 1'b0, 1'b0, 5'd12, 32'd0);
    do_reset();

    for (int unsigned n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        a  = 5'($urandom_range(10, 16));
        er = ($urandom_range(0, 7) == 0);
        w  = ($urandom_range(0, 2) == 0);
        if (er && w && a == 5'd12) w = 1'b0;
        step({$urandom_range(0, 32'h3FFF), 2'b00}, 1'($urandom_range(0, 1)),
             codes[$urandom_range(0, 7)],
             ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
             er, w, a, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception controller for the pipelined MIPS core. It produces the `req` and `EPC` values that the D-stage next-PC logic consumes, and it takes the `eret` return path. It sits at the M stage and holds the SR, Cause, EPC and PRId registers. It decides each cycle whether to take an interrupt or exception, latches the victim PC, and services `mtc0`/`mfc0` accesses.

## Interface

Parameters:
- `EXC_VECTOR`, default 32'h0000_4180: handler entry address; exported for the PC mux.
- `PRID_VALUE`, default 32'h4C5A_5142: read-only PRId contents.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc_m` in 32: PC of the instruction currently in M.
- `bd_m` in 1: the M instruction sits in a branch delay slot.
- `exc_code_m` in 5: exception code carried by the M instruction; 0 means none.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `eret_m` in 1: `eret` is in M.
- `we` in 1: `mtc0` write enable from M.
- `addr` in 5: CP0 register number for `mtc0`/`mfc0`.
- `wdata` in 32: `mtc0` data.
- `rdata` out 32: `mfc0` data, combinational.
- `req` out 1: take the exception vector this cycle; flushes the pipeline.
- `epc` out 32: current EPC register value.
- `exl` out 1: SR.EXL, for the debug view.

## Operation

Register map:
- 12 SR: IM[15:10] and EXL[1] are writable; IE[0] is writable. All other bits read 0.
- 13 Cause: BD[31], IP[15:10], ExcCode[6:2]. Software cannot write it; a write to 13 is ignored.
- 14 EPC: fully writable, but bits [1:0] are forced to 0 on write.
- 15 PRId: returns `PRID_VALUE`.
- Any other address reads 0, and a write to it is dropped.

Request generation (combinational):
- `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`
- `exc_req = (exc_code_m != 0) & ~SR.EXL`
- `req = int_req | exc_req`

Update priority on each edge (highest first):
1. `req`:
   - EXL ← 1.
   - Cause.BD ← `bd_m`.
   - Cause.ExcCode ← 0 if `int_req`, else `exc_code_m`. An interrupt beats a simultaneous exception.
   - EPC ← `bd_m ? pc_m - 4 : pc_m`, with bits [1:0] cleared.
   - `we` is ignored this cycle.
2. `eret_m`: EXL ← 0. If `we` is also set, the write still applies.
3. `we`: write the register selected by `addr`.

Other rules:
- Cause.IP ← `hw_int` on every edge, regardless of the cases above.
- A `req` and `eret_m` in the same cycle: `req` wins and EXL stays 1. EPC takes `pc_m`, so the `eret` re-executes after the handler returns.
- `rdata` reflects register state *before* the edge. There is no write-through bypass; the hazard unit stalls `mfc0` behind `mtc0` instead.
- `epc` is a direct register output. Only the consumer may add 4.

## Timing

- Reset (asynchronous, `reset_n` = 0): SR = 0, Cause = 0, EPC = 0. After reset, `req` = 0, `exl` = 0, `rdata` = 0 for every address except 15.
- `req` latency: 0 cycles. It is combinational from the M inputs and the current SR, so the PC redirect happens in the same cycle.
- Register effects appear 1 cycle later. On the edge after `req`, EXL = 1, which masks any further `req` until `eret`.
- `eret` latency: EXL clears on the edge where `eret_m` = 1. An interrupt still pending is taken on the next cycle.
- If `reset_n` falls mid-handler, all state clears at once, including EXL.
- A `hw_int` pulse shorter than one cycle may be missed. The sources hold their level.

## Structure

- Shared package `cp0_pkg` holds:
  - register numbers 12–15;
  - SR and Cause field bit positions;
  - ExcCode constants: Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12;
  - the `EXC_VECTOR` default.
- Single module. No sub-module is warranted, since request generation is three gates inside `cp0_ctrl`.

## Test plan

- **Reset and read-back:** assert `reset_n` = 0 mid-run → `req` = 0, `exl` = 0, reads of 12/13/14 = 0, read of 15 = 32'h4C5A_5142.
- **Exception in delay slot:** `pc_m` = 0x3010, `bd_m` = 1, `exc_code_m` = 12 → `req` = 1 that cycle. Next cycle: EPC = 0x300C, Cause = 0x8000_0030, EXL = 1.
- **Masked vs. enabled interrupt:** SR = 0x0000_0401, `hw_int` = 6'b000010 → `req` = 0. Then SR = 0x0000_0801 → `req` = 1, ExcCode = 0, Cause.IP = 0x0800.
- **Interrupt with exception and concurrent write:** `hw_int` enabled, `exc_code_m` = 10, `we` = 1 to EPC in the same cycle → ExcCode = 0 and EPC = `pc_m`; the write is dropped.
- **`eret` restores:** EXL = 1, `eret_m` = 1 → EXL = 0 next cycle. A pending enabled `hw_int` then gives `req` = 1 one cycle later.
- **EPC write alignment:** `mtc0` EPC with 0x0000_3007 → `epc` = 0x0000_3004. A write to address 13 leaves Cause unchanged.
